// File: rtl/seq_detector_param.sv
// Programmable symbol-sequence detector: sliding window of the last SEQ_LEN valid symbols,
// overlapping/non-overlapping detection, saturating match counter. Optional idle timeout: SEQDET_TIMEOUT_EN.
module seq_detector_param #(
    parameter int SYM_W   = 3,
    parameter int SEQ_LEN = 8,
    parameter int CNT_W   = 8,
    parameter logic [SEQ_LEN*SYM_W-1:0] RST_PATTERN =
        {3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001},
    parameter int TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_load,
    input  logic [SEQ_LEN*SYM_W-1:0]        cfg_pattern,
    input  logic                            overlap_en,
    input  logic                            data_valid,
    input  logic [SYM_W-1:0]                data,
    input  logic                            cnt_clr,
    output logic                            match,
    output logic [CNT_W-1:0]                match_count,
    output logic [$clog2(SEQ_LEN+1)-1:0]    fill_level
);

    localparam int WIN_W  = SEQ_LEN * SYM_W;
    localparam int FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if (SYM_W < 1 || SEQ_LEN < 2 || SEQ_LEN > 32 || CNT_W < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("seq_detector_param: parameter out of range");
    end

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [WIN_W-1:0]   pattern, pattern_next;
    logic [WIN_W-1:0]   window, window_next;
    logic [WIN_W-1:0]   window_shift;
    logic [FILL_W-1:0]  fill, fill_next;
    logic               match_next;
    logic [CNT_W-1:0]   count_next;
    logic               hit;

`ifdef SEQDET_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    logic [IDLE_W-1:0]  idle, idle_next;
`endif

    // Newest symbol enters at the top (symbol SEQ_LEN-1), oldest drops out of the LSBs.
    assign window_shift = {data, window[WIN_W-1:SYM_W]};

    // Prospective window is complete only if this symbol brings the fill to SEQ_LEN.
    assign hit = (fill >= FILL_LAST) && (window_shift == pattern);

    always_comb begin
        state_next   = state;
        pattern_next = pattern;
        window_next  = window;
        fill_next    = fill;
        match_next   = 1'b0;
        count_next   = match_count;
`ifdef SEQDET_TIMEOUT_EN
        idle_next    = '0;
`endif

        if (cfg_load) begin
            pattern_next = cfg_pattern;
            window_next  = '0;
            fill_next    = '0;
            state_next   = EMPTY;
        end else if (data_valid) begin
            window_next = window_shift;
            case (state)
                EMPTY: begin
                    fill_next  = FILL_W'(1);
                    state_next = FILLING;
                end
                FILLING: begin
                    fill_next = fill + FILL_W'(1);
                    if (fill == FILL_LAST) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    fill_next = FILL_FULL;
                end
                default: begin
                    fill_next  = '0;
                    state_next = EMPTY;
                end
            endcase
            if (hit) begin
                match_next = 1'b1;
                if (!overlap_en) begin
                    window_next = '0;
                    fill_next   = '0;
                    state_next  = EMPTY;
                end
            end
        end
`ifdef SEQDET_TIMEOUT_EN
        else if (state != EMPTY) begin
            if (idle == IDLE_LAST) begin
                window_next = '0;
                fill_next   = '0;
                state_next  = EMPTY;
            end else begin
                idle_next = idle + IDLE_W'(1);
            end
        end
`endif

        if (cnt_clr) begin
            count_next = '0;
        end else if (match_next && (match_count != CNT_MAX)) begin
            count_next = match_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            pattern     <= RST_PATTERN;
            window      <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
`ifdef SEQDET_TIMEOUT_EN
            idle        <= '0;
`endif
        end else begin
            state       <= state_next;
            pattern     <= pattern_next;
            window      <= window_next;
            fill        <= fill_next;
            match       <= match_next;
            match_count <= count_next;
`ifdef SEQDET_TIMEOUT_EN
            idle        <= idle_next;
`endif
        end
    end

    assign fill_level = fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default build (A) and a SEQ_LEN=3, CNT_W=2 build (B).
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        a_load, a_ovl, a_valid, a_clr, a_match;
    logic [23:0] a_pat;
    logic [2:0]  a_data;
    logic [7:0]  a_cnt;
    logic [3:0]  a_fill;

    // Instance B: SEQ_LEN=3, CNT_W=2
    logic        b_load, b_ovl, b_valid, b_clr, b_match;
    logic [8:0]  b_pat;
    logic [2:0]  b_data;
    logic [1:0]  b_cnt;
    logic [1:0]  b_fill;

    seq_detector_param dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_load(a_load), .cfg_pattern(a_pat),
        .overlap_en(a_ovl), .data_valid(a_valid), .data(a_data), .cnt_clr(a_clr),
        .match(a_match), .match_count(a_cnt), .fill_level(a_fill)
    );

    seq_detector_param #(
        .SYM_W(3), .SEQ_LEN(3), .CNT_W(2), .RST_PATTERN(9'b0), .TIMEOUT(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_load(b_load), .cfg_pattern(b_pat),
        .overlap_en(b_ovl), .data_valid(b_valid), .data(b_data), .cnt_clr(b_clr),
        .match(b_match), .match_count(b_cnt), .fill_level(b_fill)
    );

    typedef struct {
        logic        load;
        logic [23:0] pat;
        logic        ovl;
        logic        vld;
        logic [2:0]  d;
        logic        clr;
        logic        em;
        logic [7:0]  ec;
        logic [3:0]  ef;
    } vec_t;

    vec_t qa[$];
    vec_t qb[$];

    int checks = 0;
    int errors = 0;

    localparam logic [23:0] P2 = 24'hFAC688;  // symbols 0..7 = 0,1,2,...,7

    function automatic void add(inout vec_t q[$], input logic load, input logic [23:0] pat,
                                input logic ovl, input logic vld, input logic [2:0] d,
                                input logic clr, input logic em, input logic [7:0] ec,
                                input logic [3:0] ef);
        vec_t v;
        v.load = load; v.pat = pat; v.ovl = ovl; v.vld = vld; v.d = d;
        v.clr = clr; v.em = em; v.ec = ec; v.ef = ef;
        q.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic a_step(input logic load, input logic [23:0] pat, input logic ovl,
                          input logic vld, input logic [2:0] d, input logic clr);
        @(negedge clk);
        a_load = load; a_pat = pat; a_ovl = ovl; a_valid = vld; a_data = d; a_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic b_step(input logic load, input logic [8:0] pat, input logic ovl,
                          input logic vld, input logic [2:0] d, input logic clr);
        @(negedge clk);
        b_load = load; b_pat = pat; b_ovl = ovl; b_valid = vld; b_data = d; b_clr = clr;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rp [8];
    logic [2:0] six [6];

    initial begin
        rp  = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};
        six = '{3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3};
        a_load = 0; a_pat = '0; a_ovl = 1; a_valid = 0; a_data = '0; a_clr = 0;
        b_load = 0; b_pat = '0; b_ovl = 1; b_valid = 0; b_data = '0; b_clr = 0;

        // ---- Table A: reset pattern with garbage gaps, reload collision, new pattern, non-overlap, clear
        add(qa, 0, 0, 1, 1, 3'b001, 0, 0, 0, 1);
        add(qa, 0, 0, 1, 1, 3'b101, 0, 0, 0, 2);
        add(qa, 0, 0, 1, 0, 3'b111, 0, 0, 0, 2);
        add(qa, 0, 0, 1, 1, 3'b110, 0, 0, 0, 3);
        add(qa, 0, 0, 1, 0, 3'b010, 0, 0, 0, 3);
        add(qa, 0, 0, 1, 1, 3'b000, 0, 0, 0, 4);
        add(qa, 0, 0, 1, 1, 3'b110, 0, 0, 0, 5);
        add(qa, 0, 0, 1, 1, 3'b110, 0, 0, 0, 6);
        add(qa, 0, 0, 1, 0, 3'b101, 0, 0, 0, 6);
        add(qa, 0, 0, 1, 1, 3'b011, 0, 0, 0, 7);
        add(qa, 0, 0, 1, 1, 3'b101, 0, 1, 1, 8);
        add(qa, 0, 0, 1, 0, 3'b000, 0, 0, 1, 8);
        add(qa, 0, 0, 1, 1, 3'b001, 0, 0, 1, 8);
        for (int i = 0; i < 6; i++) add(qa, 0, 0, 1, 1, six[i], 0, 0, 1, 8);
        add(qa, 1, P2, 1, 1, 3'b101, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) add(qa, 0, 0, 1, 1, 3'(i), 0, 0, 1, 4'(i + 1));
        add(qa, 0, 0, 1, 1, 3'd7, 0, 1, 2, 8);
        for (int i = 0; i < 7; i++) add(qa, 0, 0, 0, 1, 3'(i), 0, 0, 2, 8);
        add(qa, 0, 0, 0, 1, 3'd7, 0, 1, 3, 0);
        add(qa, 0, 0, 0, 1, 3'd0, 0, 0, 3, 1);
        add(qa, 0, 0, 0, 0, 3'd0, 1, 0, 0, 1);

        // ---- Table B: overlap, saturation, clear, non-overlap, clear coincident with match
        add(qb, 1, 24'h1FF, 1, 0, 3'd0, 0, 0, 0, 0);
        add(qb, 0, 0, 1, 1, 3'd7, 0, 0, 0, 1);
        add(qb, 0, 0, 1, 1, 3'd7, 0, 0, 0, 2);
        add(qb, 0, 0, 1, 1, 3'd7, 0, 1, 1, 3);
        add(qb, 0, 0, 1, 1, 3'd7, 0, 1, 2, 3);
        add(qb, 0, 0, 1, 1, 3'd7, 0, 1, 3, 3);
        add(qb, 0, 0, 1, 1, 3'd7, 0, 1, 3, 3);
        add(qb, 0, 0, 1, 1, 3'd7, 0, 1, 3, 3);
        add(qb, 0, 0, 1, 0, 3'd0, 1, 0, 0, 3);
        add(qb, 1, 24'h1FF, 0, 0, 3'd0, 0, 0, 0, 0);
        add(qb, 0, 0, 0, 1, 3'd7, 0, 0, 0, 1);
        add(qb, 0, 0, 0, 1, 3'd7, 0, 0, 0, 2);
        add(qb, 0, 0, 0, 1, 3'd7, 0, 1, 1, 0);
        add(qb, 0, 0, 0, 1, 3'd7, 0, 0, 1, 1);
        add(qb, 0, 0, 0, 1, 3'd7, 0, 0, 1, 2);
        add(qb, 0, 0, 0, 1, 3'd7, 1, 1, 0, 0);
        add(qb, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);

        // ---- Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_match", 0, a_match, 0);
        check("rst_a_cnt",   0, a_cnt, 0);
        check("rst_a_fill",  0, a_fill, 0);
        check("rst_b_fill",  0, b_fill, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (qa[i]) begin
            a_step(qa[i].load, qa[i].pat, qa[i].ovl, qa[i].vld, qa[i].d, qa[i].clr);
            check("a_match", i, a_match, qa[i].em);
            check("a_cnt",   i, a_cnt,   qa[i].ec);
            check("a_fill",  i, a_fill,  qa[i].ef);
        end

        foreach (qb[i]) begin
            b_step(qb[i].load, qb[i].pat[8:0], qb[i].ovl, qb[i].vld, qb[i].d, qb[i].clr);
            check("b_match", i, b_match, qb[i].em);
            check("b_cnt",   i, b_cnt,   qb[i].ec[1:0]);
            check("b_fill",  i, b_fill,  qb[i].ef[1:0]);
        end

        // ---- Reset restores the power-up pattern; then idle-gap behaviour
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst2_fill", 0, a_fill, 0);
        check("rst2_cnt",  0, a_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) a_step(0, 0, 1, 1, rp[i], 0);
        check("gap_fill0", 0, a_fill, 5);
        for (int k = 1; k <= 16; k++) begin
            a_step(0, 0, 1, 0, 3'b111, 0);
`ifdef SEQDET_TIMEOUT_EN
            check("gap_fill", k, a_fill, (k == 16) ? 0 : 5);
`else
            check("gap_fill", k, a_fill, 5);
`endif
        end
        for (int i = 5; i < 8; i++) a_step(0, 0, 1, 1, rp[i], 0);
`ifdef SEQDET_TIMEOUT_EN
        check("gap_match", 0, a_match, 0);
        check("gap_fill_end", 0, a_fill, 3);
`else
        check("gap_match", 0, a_match, 1);
        check("gap_fill_end", 0, a_fill, 8);
`endif

        // ---- Mid-operation reset while a match pulse may be showing
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_match", 0, a_match, 0);
        check("midrst_cnt",   0, a_cnt, 0);
        check("midrst_fill",  0, a_fill, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_step(0, 0, 1, 1, rp[i], 0);
            check("post_match", i, a_match, 0);
        end
        a_step(0, 0, 1, 1, rp[7], 0);
        check("post_match", 7, a_match, 1);
        check("post_cnt",   7, a_cnt, 1);
        check("post_fill",  7, a_fill, 8);
        a_step(0, 0, 1, 0, 3'd0, 0);
        check("post_pulse_end", 8, a_match, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
